// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-ported 16-bit data memory: port A priority,
// starvation promotion for port B, bounded lock bursts, out-of-range error response.
module data_mem_arbiter #(
    parameter int DEPTH        = 128,
    parameter int STARVE_LIMIT = 4,
    parameter int LOCK_MAX     = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic        a_lock,
    input  logic [15:0] a_addr,
    input  logic [15:0] a_wdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic        b_lock,
    input  logic [15:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        a_gnt,
    output logic        b_gnt,
    output logic        a_rvalid,
    output logic        b_rvalid,
    output logic [15:0] a_rdata,
    output logic [15:0] b_rdata,
    output logic        err,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int LW = $clog2(LOCK_MAX + 1);
    localparam logic [16:0] DEPTH_W = 17'(DEPTH);

    typedef enum logic [1:0] {OWN_NONE, OWN_A, OWN_B} owner_e;

    owner_e         owner_q, owner_d;
    logic           owner_lock_q, owner_lock_d;
    logic [SW-1:0]  starve_cnt_q, starve_cnt_d;
    logic [LW-1:0]  lock_cnt_q, lock_cnt_d;
    logic           a_rvalid_q, a_rvalid_d;
    logic           b_rvalid_q, b_rvalid_d;
    logic [15:0]    a_rdata_q, a_rdata_d;
    logic [15:0]    b_rdata_q, b_rdata_d;
    logic           err_q, err_d;

    logic           lock_expired;
    logic           a_hold, b_hold;
    logic           grant_a, grant_b, any_gnt;
    logic           gnt_we, gnt_lock, in_range;
    logic [15:0]    gnt_addr, gnt_wdata;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        lock_expired = (lock_cnt_q == LW'(LOCK_MAX));
        a_hold = (owner_q == OWN_A) && owner_lock_q && a_req && !lock_expired;
        b_hold = (owner_q == OWN_B) && owner_lock_q && b_req && !lock_expired;

        // A lock beats promotion; promotion beats A's static priority.
        grant_a = a_hold ||
                  (!b_hold && a_req && !(b_req && starve_cnt_q == SW'(STARVE_LIMIT)));
        grant_b = !grant_a && b_req;

        // Grants are suppressed while reset is held low.
        a_gnt   = reset && grant_a;
        b_gnt   = reset && grant_b;
        any_gnt = a_gnt || b_gnt;

        gnt_we    = 1'b0;
        gnt_lock  = 1'b0;
        gnt_addr  = '0;
        gnt_wdata = '0;
        if (a_gnt) begin
            gnt_we    = a_we;
            gnt_lock  = a_lock;
            gnt_addr  = a_addr;
            gnt_wdata = a_wdata;
        end else if (b_gnt) begin
            gnt_we    = b_we;
            gnt_lock  = b_lock;
            gnt_addr  = b_addr;
            gnt_wdata = b_wdata;
        end

        in_range  = ({1'b0, gnt_addr} < DEPTH_W);
        mem_we    = any_gnt && gnt_we && in_range;
        mem_addr  = gnt_addr;
        mem_wdata = gnt_wdata;
    end

    always_comb begin
        owner_d      = a_gnt ? OWN_A : (b_gnt ? OWN_B : OWN_NONE);
        owner_lock_d = any_gnt && gnt_lock;

        starve_cnt_d = starve_cnt_q;
        if (!b_req || b_gnt)
            starve_cnt_d = '0;
        else if (starve_cnt_q != SW'(STARVE_LIMIT))
            starve_cnt_d = starve_cnt_q + SW'(1);

        // A burst's first locking grant counts as 1; the cycle after the limit is
        // reached arbitrates without the lock and restarts the count.
        lock_cnt_d = '0;
        if (!lock_expired && any_gnt && gnt_lock)
            lock_cnt_d = (a_hold || b_hold) ? lock_cnt_q + LW'(1) : LW'(1);

        a_rvalid_d = a_gnt;
        b_rvalid_d = b_gnt;
        err_d      = any_gnt && !in_range;

        // Out-of-range accesses answer with zero data, whether read or write.
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (a_gnt && (!a_we || !in_range))
            a_rdata_d = in_range ? mem_rdata : '0;
        if (b_gnt && (!b_we || !in_range))
            b_rdata_d = in_range ? mem_rdata : '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner_q      <= OWN_NONE;
            owner_lock_q <= 1'b0;
            starve_cnt_q <= '0;
            lock_cnt_q   <= '0;
            a_rvalid_q   <= 1'b0;
            b_rvalid_q   <= 1'b0;
            a_rdata_q    <= '0;
            b_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            owner_q      <= owner_d;
            owner_lock_q <= owner_lock_d;
            starve_cnt_q <= starve_cnt_d;
            lock_cnt_q   <= lock_cnt_d;
            a_rvalid_q   <= a_rvalid_d;
            b_rvalid_q   <= b_rvalid_d;
            a_rdata_q    <= a_rdata_d;
            b_rdata_q    <= b_rdata_d;
            err_q        <= err_d;
        end
    end

    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;
    assign err      = err_q;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 128: number of 16-bit words in the data memory.
REQ-002 SHALL have parameter STARVE_LIMIT, default 4: consecutive denied cycles before port B is promoted.
REQ-003 SHALL have parameter LOCK_MAX, default 8: maximum consecutive locked grants to one port.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have ports a_req / b_req  input  1: access request from port A (CPU load/store) or port B (DMA/debug).
REQ-007 SHALL have ports a_we / b_we  input  1: 1 = write, 0 = read; valid while x_req = 1.
REQ-008 SHALL have ports a_lock / b_lock  input  1: owner asks to keep the grant next cycle.
REQ-009 SHALL have ports a_addr / b_addr  input  16: word address.
REQ-010 SHALL have ports a_wdata / b_wdata  input  16: write data.
REQ-011 SHALL have ports a_gnt / b_gnt  output  1: combinational grant, same cycle as request.
REQ-012 SHALL have ports a_rvalid / b_rvalid  output  1: registered one-cycle response pulse.
REQ-013 SHALL have ports a_rdata / b_rdata  output  16: registered read data, valid with x_rvalid.
REQ-014 SHALL have port err  output  1: registered pulse, out-of-range access response.
REQ-015 SHALL have ports mem_we  output  1, mem_addr  output  16, mem_wdata  output  16: memory-side command.
REQ-016 SHALL have port mem_rdata  input  16: combinational read data from memory at mem_addr.

Function
REQ-017 SHALL grant at most one port per cycle; a_gnt and b_gnt never both 1.
REQ-018 SHALL drive mem_addr/mem_wdata from the granted port, and mem_we = granted x_we AND address in range.
REQ-019 SHALL drive mem_we = 0, mem_addr = 0 and mem_wdata = 0 when no port is granted.
REQ-020 SHALL treat an access as complete in its grant cycle: a write commits at that edge; for a read, mem_rdata is captured at that edge.
REQ-021 SHALL assert the granted port's x_rvalid for exactly one cycle after every grant, reads and writes alike, so latency is 1.
REQ-022 SHALL load x_rdata only on a read grant; x_rdata holds its value otherwise.
REQ-023 SHALL give port A priority on contention when there is no lock and no starvation promotion.
REQ-024 SHALL keep starve_cnt, which increments, saturating at STARVE_LIMIT, each cycle b_req = 1 and b_gnt = 0.
REQ-025 SHALL clear starve_cnt on a B grant or when b_req = 0.
REQ-026 SHALL grant B on contention when starve_cnt = STARVE_LIMIT.
REQ-027 SHALL record the owner as the port granted last cycle, or none.
REQ-028 SHALL, if the owner had x_lock = 1 last grant and x_req = 1 now, grant the owner again, overriding priority and promotion.
REQ-029 SHALL count consecutive locked grants in lock_cnt.
REQ-030 SHALL, when lock_cnt reaches LOCK_MAX, ignore the owner's lock for one arbitration cycle and then clear lock_cnt.
REQ-031 SHALL ignore x_lock from a port that is not the owner.
REQ-032 SHALL treat address >= DEPTH as out of range: grant still given, mem_we forced 0, response x_rdata = 16'h0000, err = 1 with the x_rvalid pulse.
REQ-033 SHALL let a requester deassert x_req at any cycle; the last granted access still completes its response.
REQ-034 SHALL have arbitration depend only on current inputs and state, and never on x_rvalid.

Reset
REQ-035 SHALL, on reset = 0 at any time, immediately clear x_rvalid, err, x_rdata, starve_cnt and lock_cnt, and set owner to none.
REQ-036 SHALL discard a response pending when reset asserts and never present it afterwards; grants are 0 while reset = 0.

Verification
REQ-037 SHALL cover: A writes 0x1234 to addr 5, then reads addr 5 -> a_gnt same cycle, a_rvalid the next cycle, a_rdata = 0x1234, err = 0.
REQ-038 SHALL cover: a_req and b_req held high continuously -> A granted 4 cycles, B granted on the 5th, starve_cnt then 0.
REQ-039 SHALL cover: A asserts a_lock with b_req high -> A granted 8 consecutive cycles, B granted on the 9th.
REQ-040 SHALL cover: B writes 0xBEEF to addr 200 -> b_gnt = 1, mem_we = 0, next cycle b_rvalid = 1, err = 1, b_rdata = 0x0000, memory unchanged.
REQ-041 SHALL cover: reset pulsed low in the cycle after an A read grant -> a_rvalid stays 0, all outputs 0, and A wins the first post-reset contention.
REQ-042 SHALL cover: B issues a 3-cycle locked burst while idle, and a_req rises in burst cycle 2 -> B keeps the grant until b_lock drops, then A is granted.
